// File: rtl/cp0_regfile_pkg.sv
// Shared CPU definitions: CP0 register addresses, exception codes, register
// field layouts and the exception-unit request/state types.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;

  localparam logic [2:0] CP0_SEL_PRID  = 3'd0;
  localparam logic [2:0] CP0_SEL_EBASE = 3'd1;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_MOD  = 5'd1;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        delayslot;
    logic [31:0] extra;
  } except_req_t;

  typedef struct packed {
    logic [8:0] rsv31_23;
    logic       bev;
    logic [5:0] rsv21_16;
    logic [7:0] im;
    logic [4:0] rsv7_3;
    logic       erl;
    logic       exl;
    logic       ie;
  } status_t;

  // Software interrupt bits IP[1:0] live in register bits [1:0]; bits [9:8] read 0.
  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [5:0] rsv29_24;
    logic       iv;
    logic [6:0] rsv22_16;
    logic [5:0] ip_hw;
    logic [1:0] rsv9_8;
    logic       rsv7;
    logic [4:0] exc_code;
    logic [1:0] ip_sw;
  } cause_t;

  typedef struct packed {
    status_t     status;
    cause_t      cause;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] ebase;
  } cp0_regs_t;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXCCODE_ADEL) || (code == EXCCODE_ADES) ||
           (code == EXCCODE_TLBL) || (code == EXCCODE_TLBS) ||
           (code == EXCCODE_MOD);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer with a half-rate Count.
// Optional macro CP0_TIMER_INT_EN enables the sticky timer interrupt flag (Cause.TI).
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        toggle;
  logic [31:0] count_next;

  // A Count write replaces this cycle's increment.
  always_comb begin
    count_next = count;
    if (count_wr)
      count_next = wr_data;
    else if (toggle)
      count_next = count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle  <= 1'b0;
      count   <= '0;
      compare <= '0;
    end else begin
      toggle <= ~toggle;
      count  <= count_next;
      if (compare_wr)
        compare <= wr_data;
    end
  end

`ifdef CP0_TIMER_INT_EN
  logic ti_q;

  // Writing Compare acknowledges the interrupt and wins over a same-cycle match.
  always_ff @(posedge clk) begin
    if (rst)
      ti_q <= 1'b0;
    else if (compare_wr)
      ti_q <= 1'b0;
    else if (count_next == compare)
      ti_q <= 1'b1;
  end

  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, exception/eret updates and interrupt masking.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt (Cause.TI).
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0001_8000,
  parameter logic [31:0] EBASE_INIT = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  except_req_t except_req,
  output cp0_regs_t   cp0_regs,
  output logic [7:0]  interrupt_req
);

  logic        st_bev, st_erl, st_exl, st_ie;
  logic [7:0]  st_im;
  logic        ca_bd, ca_iv;
  logic [5:0]  ca_ip_hw;
  logic [1:0]  ca_ip_sw;
  logic [4:0]  ca_exc;
  logic [31:0] epc_q, badvaddr_q;
  logic [17:0] ebase_q;

  logic        wr_ok, count_wr, compare_wr;
  logic [31:0] count, compare, ebase_v;
  logic        timer_ti;
  status_t     status_v;
  cause_t      cause_v;

  // Any exception-unit request drops a same-cycle MTC0.
  assign wr_ok      = wr_en & ~except_req.valid;
  assign count_wr   = wr_ok && wr_addr == CP0_REG_COUNT && wr_sel == 3'd0;
  assign compare_wr = wr_ok && wr_addr == CP0_REG_COMPARE && wr_sel == 3'd0;

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_wr   (count_wr),
    .compare_wr (compare_wr),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .ti         (timer_ti)
  );

  always_comb begin
    status_v     = '0;
    status_v.bev = st_bev;
    status_v.im  = st_im;
    status_v.erl = st_erl;
    status_v.exl = st_exl;
    status_v.ie  = st_ie;

    cause_v          = '0;
    cause_v.bd       = ca_bd;
    cause_v.ti       = timer_ti;
    cause_v.iv       = ca_iv;
    cause_v.ip_hw    = ca_ip_hw;
    cause_v.exc_code = ca_exc;
    cause_v.ip_sw    = ca_ip_sw;
  end

  assign ebase_v       = {EBASE_INIT[31:30], ebase_q, EBASE_INIT[11:0]};
  assign interrupt_req = {ca_ip_hw, ca_ip_sw} & st_im;

  always_comb begin
    cp0_regs          = '0;
    cp0_regs.status   = status_v;
    cp0_regs.cause    = cause_v;
    cp0_regs.epc      = epc_q;
    cp0_regs.badvaddr = badvaddr_q;
    cp0_regs.count    = count;
    cp0_regs.compare  = compare;
    cp0_regs.ebase    = ebase_v;
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel == 3'd0) begin
      case (rd_addr)
        CP0_REG_BADVADDR: rd_data = badvaddr_q;
        CP0_REG_COUNT:    rd_data = count;
        CP0_REG_COMPARE:  rd_data = compare;
        CP0_REG_STATUS:   rd_data = status_v;
        CP0_REG_CAUSE:    rd_data = cause_v;
        CP0_REG_EPC:      rd_data = epc_q;
        CP0_REG_PRID:     rd_data = PRID_VALUE;
        default:          rd_data = '0;
      endcase
    end else if (rd_sel == CP0_SEL_EBASE && rd_addr == CP0_REG_PRID) begin
      rd_data = ebase_v;
    end
  end

  // Hardware interrupt sampling runs every cycle; exception beats eret beats MTC0.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_bev     <= 1'b1;
      st_im      <= '0;
      st_erl     <= 1'b0;
      st_exl     <= 1'b0;
      st_ie      <= 1'b0;
      ca_bd      <= 1'b0;
      ca_iv      <= 1'b0;
      ca_ip_hw   <= '0;
      ca_ip_sw   <= '0;
      ca_exc     <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      ebase_q    <= EBASE_INIT[29:12];
    end else begin
      ca_ip_hw <= {hw_int[5] | timer_ti, hw_int[4:0]};
      if (except_req.valid && !except_req.eret) begin
        ca_exc <= except_req.code;
        if (!st_exl) begin
          epc_q  <= except_req.delayslot ? except_req.pc - 32'd4 : except_req.pc;
          ca_bd  <= except_req.delayslot;
          st_exl <= 1'b1;
        end
        if (is_addr_exc(except_req.code))
          badvaddr_q <= except_req.extra;
      end else if (except_req.valid) begin
        if (st_erl)
          st_erl <= 1'b0;
        else
          st_exl <= 1'b0;
      end else if (wr_en && wr_sel == 3'd0) begin
        case (wr_addr)
          CP0_REG_STATUS: begin
            st_bev <= wr_data[22];
            st_im  <= wr_data[15:8];
            st_erl <= wr_data[2];
            st_exl <= wr_data[1];
            st_ie  <= wr_data[0];
          end
          CP0_REG_CAUSE: begin
            ca_iv    <= wr_data[23];
            ca_ip_sw <= wr_data[1:0];
          end
          CP0_REG_EPC: epc_q <= wr_data;
          default: ;
        endcase
      end else if (wr_en && wr_sel == CP0_SEL_EBASE && wr_addr == CP0_REG_PRID) begin
        ebase_q <= wr_data[29:12];
      end
    end
  end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 SHALL have parameter PRID_VALUE, default 32'h0001_8000, which is the read-only PRId value (reg 15 sel 0).
REQ-002 SHALL have parameter EBASE_INIT, default 32'h8000_0000, which is the EBase reset value (reg 15 sel 1).
REQ-003 SHALL have the following ports; there is one clock, and reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hw_int  in  6  external hardware interrupt lines
- rd_addr  in  5  and  rd_sel  in  3  MFC0 register select
- rd_data  out  32  MFC0 read data (combinational)
- wr_en  in  1  MTC0 strobe
- wr_addr  in  5  and  wr_sel  in  3  MTC0 register select
- wr_data  in  32  MTC0 data
- except_req  in  except_req_t  exception/eret request from the exception unit
- cp0_regs  out  cp0_regs_t  current register state to the exception unit
- interrupt_req  out  8  pending and unmasked interrupts (Cause.IP & Status.IM)

Function
REQ-010 SHALL implement BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15/0), EBase(15/1). Any other address SHALL read 0, and writes to it SHALL be ignored.
REQ-011 MTC0 write masks: Status writes IM[15:8], BEV[22], ERL[2], EXL[1] and IE[0] only; Cause writes IV[23] and IP[1:0] only; EBase writes [29:12] only; BadVAddr and PRId are read-only. The write is visible on the next cycle; there is no read bypass.
REQ-012 Count SHALL increment by 1 every second cycle using an internal toggle bit, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-013 An MTC0 write to Count SHALL load wr_data and suppress that cycle's increment.
REQ-014 Cause.IP[7:2] SHALL be registered each cycle as {hw_int[5] | Cause.TI, hw_int[4:0]}, giving 1-cycle latency.
REQ-015 interrupt_req SHALL equal Cause.IP & Status.IM, derived combinationally from registers.
REQ-016 When except_req.valid=1 and except_req.eret=0:
- Cause.ExcCode <= except_req.code.
- If Status.EXL=0: EPC <= delayslot ? pc-4 : pc; Cause.BD <= delayslot; Status.EXL <= 1.
- If Status.EXL=1: EPC, BD and EXL are unchanged.
REQ-017 For code AdEL, AdES, TLBL, TLBS or Mod, BadVAddr SHALL be loaded from except_req.extra; for any other code, BadVAddr is unchanged.
REQ-018 When except_req.valid=1 and except_req.eret=1: if Status.ERL=1, clear ERL; otherwise clear EXL. No other register changes.
REQ-019 If an exception update and an MTC0 write occur in the same cycle, the exception update SHALL win and the MTC0 write SHALL be dropped entirely.
REQ-020 The timer and hardware interrupt fields SHALL update even in a cycle that has an exception.
REQ-021 cp0_regs SHALL reflect registered state only, with no combinational path from except_req or wr_*.

Reset
REQ-030 On a cycle with rst=1, registers SHALL take these values:
- Status=32'h0040_0000 (BEV=1, all else 0)
- Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, toggle=0
- EBase=EBASE_INIT
REQ-031 Reset SHALL take priority over except_req and MTC0 in the same cycle; a request arriving mid-operation under reset is discarded.
REQ-032 After reset, interrupt_req=8'h00 until the first post-reset clock edge that samples IP.

Configuration
REQ-040 Macro CP0_TIMER_INT_EN, when defined: Cause.TI (bit 30) SHALL be set, and remain set, on the cycle Count equals Compare after update. An MTC0 write to Compare SHALL clear TI, and the Compare write has priority over a simultaneous match.
REQ-041 When CP0_TIMER_INT_EN is not defined: Cause.TI SHALL read 0, IP[7] SHALL equal hw_int[5] only, and Count/Compare SHALL still be readable and writable.

Structure
REQ-050 cp0_regs_t, the status_t and cause_t field structs, CP0_REG_* address constants and EXCCODE_* SHALL live in the shared CPU definitions package, alongside except_req_t.
REQ-051 Count, Compare and TI logic SHALL be one sub-module, cp0_timer, instantiated once inside cp0_regfile.

Verification
REQ-060 Reset, then read Status, EBase and Count -> 32'h0040_0000, 32'h8000_0000 and 0; after 10 cycles Count=5.
REQ-061 MTC0 Status=32'hFFFF_FFFF -> Status reads 32'h0040_FF07.
REQ-062 MTC0 Cause=32'hFFFF_FFFF -> Cause reads 32'h0080_0003.
REQ-063 except_req {valid=1, code=AdEL, pc=32'hBFC0_0104, delayslot=1, extra=32'h0000_0003} with EXL=0 -> next cycle:
- EPC=32'hBFC0_0100, Cause.BD=1, ExcCode=4, EXL=1
- BadVAddr=32'h0000_0003
A second exception with code=Sys -> ExcCode=8; EPC and BD are unchanged.
REQ-064 Set EXL=1, ERL=1, then send eret -> ERL=0, EXL=1; send eret again -> EXL=0.
REQ-065 Same-cycle MTC0 EPC=32'h1234 and a Break exception at pc=32'h8000_0010 -> EPC=32'h8000_0010.
REQ-066 With CP0_TIMER_INT_EN defined and IM[7]=1: Compare=20, Count=0 -> TI and interrupt_req[7] set once Count reaches 20. Then MTC0 Compare=100 -> TI clears and interrupt_req=0. Also hw_int=6'b000001 with IM[2]=1 -> interrupt_req=8'h04 one cycle later.
